// File: rtl/inst_pkg.sv
// Shared types and constants for the instruction ROM: FSM states, the
// reserved HALT/NOP encodings and the default geometry.
package inst_pkg;
  localparam int T_DEF = 10;
  localparam int W_DEF = 9;

  localparam logic [W_DEF-1:0] HALT_OPCODE = '1;
  localparam logic [W_DEF-1:0] NOP         = '0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } state_t;
endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, one registered read port, no reset,
// so it can map onto a block RAM.
module inst_mem_array #(
  parameter int T = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         we,
  input  logic [T-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [T-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**T];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/inst_rom.sv
// Loadable instruction ROM: accepts a program stream, then serves fetches
// with 1-cycle latency, flags out-of-range reads and latches HALT.
module inst_rom
  import inst_pkg::*;
#(
  parameter int T = T_DEF,
  parameter int W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [T-1:0] ProgCtr,
  input  logic         Start,
  input  logic         LoadValid,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadReady,
  output logic [W-1:0] Instruction,
  output logic         InstValid,
  output logic         Done,
  output logic         LoadErr,
  output logic         OutOfRange
);
  // Reserved encodings stretched to this instance's word width.
  localparam logic [W-1:0] HALT_W = {W{HALT_OPCODE[0]}};
  localparam logic [W-1:0] NOP_W  = {W{NOP[0]}};
  localparam logic [T:0]   FULL   = {1'b1, {T{1'b0}}};

  state_t       state_q, state_d;
  logic [T-1:0] wr_ptr;
  logic [T:0]   length;
  logic         accept, wr_end, halt_now, re;
  logic         rd_seen, rd_oor;
  logic [W-1:0] rdata;

  assign LoadReady = (state_q == LOAD);
  assign accept    = LoadReady && LoadValid;
  assign wr_end    = (wr_ptr == {T{1'b1}});
  assign halt_now  = (state_q == RUN) && InstValid && (Instruction == HALT_W);
  assign re        = (state_q == RUN) && !halt_now;
  assign Done      = (state_q == HALT) || halt_now;

  // rdata is unreset RAM output; mask it until a real in-range sample exists.
  assign Instruction = (rd_seen && !rd_oor) ? rdata : NOP_W;
  assign OutOfRange  = InstValid && rd_oor;

  inst_mem_array #(.T(T), .W(W)) u_mem (
    .Clk   (Clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (LoadData),
    .re    (re),
    .raddr (ProgCtr),
    .rdata (rdata)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && (LoadLast || wr_end)) state_d = READY;
      READY:   if (Start) state_d = RUN;
      RUN:     if (halt_now) state_d = HALT;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      length    <= '0;
      LoadErr   <= 1'b0;
      InstValid <= 1'b0;
      rd_seen   <= 1'b0;
      rd_oor    <= 1'b0;
    end else begin
      if (accept) begin
        if (LoadLast) begin
          length <= {1'b0, wr_ptr} + {{T{1'b0}}, 1'b1};
        end else if (wr_end) begin
          length  <= FULL;
          LoadErr <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + {{(T-1){1'b0}}, 1'b1};
        end
      end
      InstValid <= re;
      if (re) begin
        rd_seen <= 1'b1;
        rd_oor  <= ({1'b0, ProgCtr} >= length);
      end
    end
  end
endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom (T=3): a mode-level program/fetch model is
// checked every cycle, plus hand-computed literal expectations.
module tb_inst_rom;
  localparam int T = 3;
  localparam int W = 9;
  localparam int DEPTH = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic [T-1:0] ProgCtr = '0;
  logic         Start = 1'b0;
  logic         LoadValid = 1'b0;
  logic [W-1:0] LoadData = '0;
  logic         LoadLast = 1'b0;
  logic         LoadReady, InstValid, Done, LoadErr, OutOfRange;
  logic [W-1:0] Instruction;

  int n_cmp = 0;
  int n_bad = 0;

  inst_rom #(.T(T), .W(W)) dut (
    .Clk(Clk), .Reset(Reset), .ProgCtr(ProgCtr), .Start(Start),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadLast(LoadLast),
    .LoadReady(LoadReady), .Instruction(Instruction), .InstValid(InstValid),
    .Done(Done), .LoadErr(LoadErr), .OutOfRange(OutOfRange)
  );

  always #5 Clk = ~Clk;

  // Model: 0 = loading, 1 = waiting for start, 2 = running, 3 = halted.
  int         m_mode, m_len, m_wp;
  logic [8:0] m_mem [DEPTH];
  logic [8:0] m_inst;
  bit         m_iv, m_oor, m_err;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode <= 0; m_len <= 0; m_wp <= 0;
      m_inst <= '0; m_iv <= 0; m_oor <= 0; m_err <= 0;
    end else begin
      m_iv <= 0;
      case (m_mode)
        0: if (LoadValid) begin
          m_mem[m_wp] <= LoadData;
          if (LoadLast) begin
            m_len <= m_wp + 1; m_mode <= 1;
          end else if (m_wp == DEPTH - 1) begin
            m_len <= DEPTH; m_err <= 1; m_mode <= 1;
          end else m_wp <= m_wp + 1;
        end
        1: if (Start) m_mode <= 2;
        2: if (m_iv && m_inst == 9'h1FF) m_mode <= 3;
           else begin
             m_iv <= 1;
             if (int'(ProgCtr) >= m_len) begin m_inst <= '0; m_oor <= 1; end
             else begin m_inst <= m_mem[ProgCtr]; m_oor <= 0; end
           end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      chk("m.LoadReady",   32'(LoadReady),   32'(m_mode == 0));
      chk("m.InstValid",   32'(InstValid),   32'(m_iv));
      chk("m.Instruction", 32'(Instruction), 32'(m_inst));
      chk("m.OutOfRange",  32'(OutOfRange),  32'(m_iv && m_oor));
      chk("m.LoadErr",     32'(LoadErr),     32'(m_err));
      chk("m.Done",        32'(Done),
          32'(m_mode == 3 || (m_mode == 2 && m_iv && m_inst == 9'h1FF)));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0; LoadValid = 0; LoadLast = 0; Start = 0; ProgCtr = '0;
    cyc(2);
    Reset = 1'b1;
  endtask

  task automatic load(input logic [8:0] d, input bit last);
    LoadValid = 1; LoadData = d; LoadLast = last;
    cyc();
    LoadValid = 0; LoadLast = 0;
  endtask

  // Start pulse; returns at the first RUN cycle's falling edge.
  task automatic start();
    Start = 1; cyc(); Start = 0;
  endtask

  task automatic fetch(input logic [T-1:0] pc);
    ProgCtr = pc; cyc();
  endtask

  initial begin
    do_reset();
    chk("rst.LoadReady", 32'(LoadReady), 32'd1);
    chk("rst.Done", 32'(Done), 32'd0);
    chk("rst.InstValid", 32'(InstValid), 32'd0);
    chk("rst.Instruction", 32'(Instruction), 32'd0);

    // Start while loading is ignored.
    Start = 1; cyc(); Start = 0; cyc();
    chk("load.start_ignored", 32'(LoadReady), 32'd1);

    load(9'h011, 0); load(9'h022, 0); load(9'h1FF, 1);
    chk("load.ready_low", 32'(LoadReady), 32'd0);
    start();
    chk("run.first_iv", 32'(InstValid), 32'd0);
    fetch(0);
    chk("run.i0", 32'(Instruction), 32'h011);
    chk("run.iv0", 32'(InstValid), 32'd1);
    fetch(1);
    chk("run.i1", 32'(Instruction), 32'h022);
    fetch(2);
    chk("run.i2", 32'(Instruction), 32'h1FF);
    chk("run.done_with_halt", 32'(Done), 32'd1);
    fetch(0);
    chk("halt.iv", 32'(InstValid), 32'd0);
    chk("halt.done", 32'(Done), 32'd1);
    chk("halt.hold", 32'(Instruction), 32'h1FF);
    cyc(2);

    // Out-of-range fetch; a load attempt while running must not write.
    do_reset();
    load(9'h0A1, 0); load(9'h0B2, 1);
    start();
    fetch(5);
    chk("oor.inst", 32'(Instruction), 32'd0);
    chk("oor.flag", 32'(OutOfRange), 32'd1);
    chk("oor.iv", 32'(InstValid), 32'd1);
    chk("oor.done", 32'(Done), 32'd0);
    LoadValid = 1; LoadData = 9'h0AA;
    fetch(2);
    chk("oor.len_edge", 32'(OutOfRange), 32'd1);
    chk("run.loadready", 32'(LoadReady), 32'd0);
    LoadValid = 0;
    fetch(1);
    chk("run.no_write", 32'(Instruction), 32'h0B2);
    chk("run.in_range", 32'(OutOfRange), 32'd0);
    fetch(0);
    chk("run.w0", 32'(Instruction), 32'h0A1);

    // Fill the array without LoadLast.
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(9'(9'h100 + i), 0);
    chk("full.err", 32'(LoadErr), 32'd1);
    chk("full.ready", 32'(LoadReady), 32'd0);
    load(9'h0EE, 0);
    start();
    fetch(7);
    chk("full.w7", 32'(Instruction), 32'h107);
    chk("full.oor7", 32'(OutOfRange), 32'd0);
    fetch(0);
    chk("full.w0", 32'(Instruction), 32'h100);

    // Reset mid-load, then a 1-word program.
    do_reset();
    load(9'h0C1, 0); load(9'h0C2, 0);
    Reset = 0; #1;
    chk("midrst.ready", 32'(LoadReady), 32'd1);
    chk("midrst.err", 32'(LoadErr), 32'd0);
    chk("midrst.iv", 32'(InstValid), 32'd0);
    chk("midrst.inst", 32'(Instruction), 32'd0);
    cyc();
    Reset = 1;
    load(9'h033, 1);
    start();
    fetch(1);
    chk("midrst.oor", 32'(OutOfRange), 32'd1);
    chk("midrst.oor_inst", 32'(Instruction), 32'd0);
    fetch(0);
    chk("midrst.w0", 32'(Instruction), 32'h033);

    // Reset in HALT clears Done without a clock edge.
    do_reset();
    load(9'h1FF, 1);
    start();
    fetch(0);
    cyc();
    chk("halt2.done", 32'(Done), 32'd1);
    #2 Reset = 0;
    #1 chk("async.done", 32'(Done), 32'd0);
    cyc();
    Reset = 1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
